// File: rtl/drum_seq_pkg.sv
// Shared defaults, voice/state enums and the step-length helper for the drum step sequencer.
// Types only: no latency, no backpressure.
package drum_seq_pkg;

  localparam int DEF_NUM_VOICES = 4;
  localparam int DEF_NUM_STEPS  = 16;
  localparam int DEF_TRIG_HOLD  = 4;

  typedef enum logic [1:0] {
    VOICE_KICK  = 2'd0,
    VOICE_SNARE = 2'd1,
    VOICE_HIHAT = 2'd2,
    VOICE_CLAP  = 2'd3
  } voice_e;

  typedef logic [DEF_NUM_STEPS-1:0] pattern_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } seq_state_e;

  // Step length never drops below two hold periods, so a retrigger always sees a low gap.
  function automatic logic [15:0] eff_len(input logic [15:0] sps, input int hold);
    logic [15:0] min_len;
    min_len = 16'(2 * hold);
    return (sps > min_len) ? sps : min_len;
  endfunction

endpackage

// File: rtl/pblrc_tick_gen.sv
// Synchronises pblrc into mclk and emits a one-cycle pulse per rising edge.
// Latency: pulse is high in the third mclk cycle after the edge; no backpressure.
module pblrc_tick_gen (
  input  logic mclk,
  input  logic rst,
  input  logic pblrc,
  output logic sample_tick
);

  // [0],[1] are the two-flop synchroniser, [2] holds the previous synchronised level.
  logic [2:0] sync;

  always_ff @(posedge mclk or negedge rst) begin
    if (!rst) begin
      sync <= '0;
    end else begin
      sync <= {sync[1:0], pblrc};
    end
  end

  assign sample_tick = sync[1] & ~sync[2];

endmodule

// File: rtl/drum_step_sequencer.sv
// Step sequencer: walks a per-voice step pattern at a sample-rate tempo and fires hold-timed triggers.
// Latency: outputs registered, one mclk after the sample tick; no backpressure, writes always accepted.
module drum_step_sequencer
  import drum_seq_pkg::*;
#(
  parameter int NUM_VOICES = DEF_NUM_VOICES,
  parameter int NUM_STEPS  = DEF_NUM_STEPS,
  parameter int TRIG_HOLD  = DEF_TRIG_HOLD
) (
  input  logic                          mclk,
  input  logic                          rst,
  input  logic                          pblrc,
  input  logic                          run,
  input  logic [15:0]                   samples_per_step,
  input  logic                          pattern_wr,
  input  logic [$clog2(NUM_VOICES)-1:0] pattern_voice,
  input  logic [NUM_STEPS-1:0]          pattern_data,
  output logic                          pattern_ack,
  output logic [NUM_VOICES-1:0]         trig,
  output logic [$clog2(NUM_STEPS)-1:0]  step_idx,
  output logic                          step_strobe
);

  localparam int SW = $clog2(NUM_STEPS);
  localparam int HW = $clog2(TRIG_HOLD + 1);
  localparam logic [SW-1:0] LAST_STEP = SW'(NUM_STEPS - 1);
  localparam logic [HW-1:0] HOLD_LOAD = HW'(TRIG_HOLD);

  logic                  sample_tick;
  seq_state_e            state;
  logic [15:0]           sample_cnt;
  logic [15:0]           cur_len;
  logic [NUM_STEPS-1:0]  active [NUM_VOICES];
  logic [NUM_STEPS-1:0]  shadow [NUM_VOICES];
  logic [HW-1:0]         hold_cnt [NUM_VOICES];
  logic [NUM_VOICES-1:0] pending;
  logic [NUM_VOICES-1:0] wr_mask;
  logic [NUM_VOICES-1:0] commit_mask;
  logic [NUM_VOICES-1:0] fire_mask;
  logic                  running_tick;
  logic                  step_fire;
  logic                  at_wrap;
  logic                  pattern_wrap;
  logic                  commit;

  pblrc_tick_gen u_tick_gen (
    .mclk        (mclk),
    .rst         (rst),
    .pblrc       (pblrc),
    .sample_tick (sample_tick)
  );

  always_comb begin
    wr_mask = '0;
    if (pattern_wr) begin
      wr_mask[pattern_voice] = 1'b1;
    end

    running_tick = (state == ST_RUN) && run && sample_tick;
    step_fire    = running_tick && (sample_cnt == 16'd0);
    at_wrap      = running_tick && (sample_cnt == cur_len - 16'd1);
    pattern_wrap = at_wrap && (step_idx == LAST_STEP);

    // Commits use the pending set as it stood before this cycle, so a same-cycle write waits.
    commit      = (|pending) && ((state == ST_IDLE) || pattern_wrap);
    commit_mask = commit ? pending : '0;

    fire_mask = '0;
    for (int v = 0; v < NUM_VOICES; v++) begin
      fire_mask[v] = step_fire && active[v][step_idx];
    end
  end

  always_ff @(posedge mclk or negedge rst) begin
    if (!rst) begin
      state       <= ST_IDLE;
      step_idx    <= '0;
      sample_cnt  <= '0;
      cur_len     <= '0;
      trig        <= '0;
      step_strobe <= 1'b0;
      pattern_ack <= 1'b0;
      pending     <= '0;
      for (int v = 0; v < NUM_VOICES; v++) begin
        active[v]   <= '0;
        shadow[v]   <= '0;
        hold_cnt[v] <= '0;
      end
    end else begin
      step_strobe <= step_fire;
      pattern_ack <= commit;
      pending     <= (pending & ~commit_mask) | wr_mask;

      for (int v = 0; v < NUM_VOICES; v++) begin
        if (wr_mask[v]) begin
          shadow[v] <= pattern_data;
        end
        if (commit_mask[v]) begin
          active[v] <= shadow[v];
        end
      end

      case (state)
        ST_IDLE: begin
          if (run) begin
            state      <= ST_RUN;
            step_idx   <= '0;
            sample_cnt <= '0;
            cur_len    <= eff_len(samples_per_step, TRIG_HOLD);
          end
        end

        ST_RUN: begin
          if (!run) begin
            state      <= ST_IDLE;
            step_idx   <= '0;
            sample_cnt <= '0;
            trig       <= '0;
            for (int v = 0; v < NUM_VOICES; v++) begin
              hold_cnt[v] <= '0;
            end
          end else if (sample_tick) begin
            // A fire reloads the hold even if the voice is still high from the previous step.
            for (int v = 0; v < NUM_VOICES; v++) begin
              if (fire_mask[v]) begin
                hold_cnt[v] <= HOLD_LOAD;
                trig[v]     <= 1'b1;
              end else if (hold_cnt[v] != '0) begin
                hold_cnt[v] <= hold_cnt[v] - 1'b1;
                if (hold_cnt[v] == HW'(1)) begin
                  trig[v] <= 1'b0;
                end
              end
            end

            if (at_wrap) begin
              sample_cnt <= '0;
              step_idx   <= (step_idx == LAST_STEP) ? '0 : step_idx + 1'b1;
              cur_len    <= eff_len(samples_per_step, TRIG_HOLD);
            end else begin
              sample_cnt <= sample_cnt + 16'd1;
            end
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_drum_step_sequencer.sv
// Scoreboarded bench for drum_step_sequencer: expected step fires and commit acks are queued
// with the stimulus and matched against the DUT as strobes/acks appear.
module tb_drum_step_sequencer;
  import drum_seq_pkg::*;

  localparam int NV = 4;
  localparam int NS = 16;
  localparam int TH = 4;

  logic          mclk = 1'b0;
  logic          rst = 1'b0;
  logic          pblrc = 1'b0;
  logic          run = 1'b0;
  logic [15:0]   samples_per_step = 16'd100;
  logic          pattern_wr = 1'b0;
  logic [1:0]    pattern_voice = '0;
  logic [NS-1:0] pattern_data = '0;
  logic          pattern_ack;
  logic [NV-1:0] trig;
  logic [3:0]    step_idx;
  logic          step_strobe;

  typedef struct {
    int         rel;
    int         step;
    logic [3:0] trig;
  } ev_t;

  ev_t sb_q[$];
  int  ack_q[$];
  int  n_chk = 0;
  int  n_fail = 0;
  int  smp_cnt = 0;
  int  base = 0;
  int  popped = 0;
  bit  ack_sb_en = 1'b0;

  drum_step_sequencer #(
    .NUM_VOICES (NV),
    .NUM_STEPS  (NS),
    .TRIG_HOLD  (TH)
  ) dut (
    .mclk             (mclk),
    .rst              (rst),
    .pblrc            (pblrc),
    .run              (run),
    .samples_per_step (samples_per_step),
    .pattern_wr       (pattern_wr),
    .pattern_voice    (pattern_voice),
    .pattern_data     (pattern_data),
    .pattern_ack      (pattern_ack),
    .trig             (trig),
    .step_idx         (step_idx),
    .step_strobe      (step_strobe)
  );

  always #5 mclk = ~mclk;

  // One audio sample every 8 mclk; smp_cnt counts pblrc rising edges.
  initial begin
    forever begin
      repeat (4) @(negedge mclk);
      smp_cnt = smp_cnt + 1;
      pblrc = 1'b1;
      repeat (4) @(negedge mclk);
      pblrc = 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Monitor: strobes and acks against the scoreboards, trig hold widths and low gaps.
  int         rise_smp [NV];
  int         fall_smp [NV];
  bit         fall_vld [NV];
  logic [3:0] trig_d = '0;
  logic [3:0] prev_step = '0;

  always @(negedge mclk) begin
    ev_t e;
    int  a;
    if (step_strobe) begin
      if (sb_q.size() == 0) begin
        chk("strobe_unexpected", 32'd1, 32'd0);
      end else begin
        e = sb_q.pop_front();
        chk("strobe_rel", smp_cnt - base, e.rel);
        chk("strobe_step", step_idx, e.step);
        chk("strobe_trig", trig, e.trig);
        popped++;
      end
    end
    if (pattern_ack && ack_sb_en) begin
      if (ack_q.size() == 0) begin
        chk("ack_unexpected", 32'd1, 32'd0);
      end else begin
        a = ack_q.pop_front();
        chk("ack_rel", smp_cnt - base, a);
        chk("ack_prev_step", prev_step, NS - 1);
        chk("ack_step", step_idx, 0);
      end
    end
    for (int v = 0; v < NV; v++) begin
      if (trig[v] && !trig_d[v]) begin
        if (fall_vld[v]) chk("trig_gap_ok", (smp_cnt - fall_smp[v]) >= TH, 32'd1);
        rise_smp[v] = smp_cnt;
      end
      if (!trig[v] && trig_d[v]) begin
        if (run && rst) begin
          chk("trig_hold", smp_cnt - rise_smp[v], TH);
          fall_smp[v] = smp_cnt;
          fall_vld[v] = 1'b1;
        end else begin
          fall_vld[v] = 1'b0;
        end
      end
    end
    trig_d = trig;
    prev_step = step_idx;
  end

  task automatic push(input int rel, input int step, input logic [3:0] t);
    ev_t e;
    e.rel = rel;
    e.step = step;
    e.trig = t;
    sb_q.push_back(e);
  endtask

  // Sets run just after a pblrc fall so the first tick in RUN is sample rel=1.
  task automatic start_run();
    @(negedge pblrc);
    @(negedge mclk);
    base = smp_cnt;
    run = 1'b1;
  endtask

  task automatic stop_run();
    @(negedge mclk);
    run = 1'b0;
    repeat (2) @(negedge mclk);
  endtask

  task automatic wait_sb(input int budget);
    for (int i = 0; i < budget && sb_q.size() != 0; i++) @(negedge mclk);
    chk("sb_drained", sb_q.size(), 0);
  endtask

  task automatic wr_pulse(input logic [1:0] v, input logic [NS-1:0] d);
    pattern_wr = 1'b1;
    pattern_voice = v;
    pattern_data = d;
    @(negedge mclk);
    pattern_wr = 1'b0;
  endtask

  task automatic wr_idle(input logic [1:0] v, input logic [NS-1:0] d);
    @(negedge mclk);
    wr_pulse(v, d);
    chk("ack_early", pattern_ack, 1'b0);
    @(negedge mclk);
    chk("ack_idle", pattern_ack, 1'b1);
    @(negedge mclk);
    chk("ack_single", pattern_ack, 1'b0);
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int p0;
    pattern_t hh;
    hh = 16'h5555;
    for (int v = 0; v < NV; v++) fall_vld[v] = 1'b0;

    // Reset state
    repeat (3) @(negedge mclk);
    chk("rst_trig", trig, 4'h0);
    chk("rst_step", step_idx, 4'h0);
    chk("rst_strobe", step_strobe, 1'b0);
    chk("rst_ack", pattern_ack, 1'b0);
    rst = 1'b1;

    // Hihat on even steps, 100-sample steps
    wr_idle(VOICE_HIHAT, hh);
    samples_per_step = 16'd100;
    for (int n = 0; n < 5; n++) push(1 + 100 * n, n, (n % 2 == 0) ? 4'b0100 : 4'b0000);
    start_run();
    wait_sb(6000);
    stop_run();

    // Short step clamped to 2*TRIG_HOLD; snare on every step gives the minimum gap; covers wrap
    wr_idle(VOICE_SNARE, 16'hFFFF);
    samples_per_step = 16'd3;
    for (int n = 0; n < NS + 2; n++) push(1 + 8 * n, n % NS, (n % 2 == 0) ? 4'b0110 : 4'b0010);
    start_run();
    wait_sb(2000);
    stop_run();

    // Kick written mid-pattern commits at the wrap; clap written in the wrap cycle waits a pattern
    samples_per_step = 16'd8;
    for (int n = 0; n < NS; n++) push(1 + 8 * n, n, (n % 2 == 0) ? 4'b0110 : 4'b0010);
    for (int n = 0; n < NS; n++) push(129 + 8 * n, n, (n % 2 == 0) ? 4'b0111 : 4'b0011);
    push(257, 0, 4'b1111);
    ack_q.push_back(128);
    ack_q.push_back(256);
    ack_sb_en = 1'b1;
    p0 = popped;
    start_run();
    for (int i = 0; i < 1000 && (popped - p0) < 6; i++) @(negedge mclk);
    chk("at_step5", step_idx, 5);
    wr_pulse(VOICE_KICK, 16'hFFFF);
    for (int i = 0; i < 200 && (smp_cnt - base) < 128; i++) @(posedge pblrc);
    @(negedge mclk);
    @(negedge mclk);
    wr_pulse(VOICE_CLAP, 16'hFFFF);
    wait_sb(3000);
    chk("ack_q_drained", ack_q.size(), 0);
    stop_run();
    ack_sb_en = 1'b0;

    // Drop run while triggers are high at step 7, then restart at step 0
    for (int n = 0; n < 8; n++) push(1 + 8 * n, n, (n % 2 == 0) ? 4'b1111 : 4'b1011);
    start_run();
    wait_sb(1000);
    chk("trig_before_drop", trig, 4'b1011);
    run = 1'b0;
    @(negedge mclk);
    chk("drop_trig", trig, 4'h0);
    chk("drop_step", step_idx, 0);
    push(1, 0, 4'b1111);
    start_run();
    wait_sb(200);
    stop_run();

    // Reset mid-hold: trig drops at once and every pattern is gone
    push(1, 0, 4'b1111);
    start_run();
    wait_sb(200);
    repeat (3) @(negedge mclk);
    #2 rst = 1'b0;
    #1;
    chk("arst_trig", trig, 4'h0);
    chk("arst_step", step_idx, 0);
    run = 1'b0;
    repeat (2) @(negedge mclk);
    rst = 1'b1;
    for (int n = 0; n < 3; n++) push(1 + 8 * n, n, 4'b0000);
    start_run();
    wait_sb(400);
    stop_run();
    wr_idle(VOICE_HIHAT, hh);

    // Tempo change mid-step applies from the next step
    samples_per_step = 16'd100;
    push(1, 0, 4'b0100);
    push(101, 1, 4'b0000);
    push(151, 2, 4'b0100);
    push(201, 3, 4'b0000);
    start_run();
    for (int i = 0; i < 1000 && (smp_cnt - base) < 30; i++) @(negedge mclk);
    samples_per_step = 16'd50;
    wait_sb(3000);
    stop_run();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/drum_step_sequencer.md
DRUM_STEP_SEQUENCER -- requirements
Module: drum_step_sequencer

Interface
REQ-001 SHALL have parameter NUM_VOICES, default 4, number of trigger outputs (voices).
REQ-002 SHALL have parameter NUM_STEPS, default 16, pattern length in steps.
REQ-003 SHALL have parameter TRIG_HOLD, default 4, trigger high time in audio samples.
REQ-004 SHALL have port mclk  in  1  master clock (256x sample rate); the only clock.
REQ-005 SHALL have port rst  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port pblrc  in  1  playback LR clock, treated as data and sampled in mclk.
REQ-007 SHALL have port run  in  1  level; 1 = sequencer playing.
REQ-008 SHALL have port samples_per_step  in  16  step length in samples (tempo).
REQ-009 SHALL have port pattern_wr  in  1  one-cycle pattern write strobe.
REQ-010 SHALL have port pattern_voice  in  $clog2(NUM_VOICES)  voice index of the write.
REQ-011 SHALL have port pattern_data  in  NUM_STEPS  step-enable bits; bit n = step n.
REQ-012 SHALL have port pattern_ack  out  1  one-cycle pulse when pending writes commit.
REQ-013 SHALL have port trig  out  NUM_VOICES  per-voice trigger level to the oneshot voices.
REQ-014 SHALL have port step_idx  out  $clog2(NUM_STEPS)  step currently playing.
REQ-015 SHALL have port step_strobe  out  1  one-cycle pulse at each step fire.

Function
REQ-016 SHALL synchronise pblrc with two flops; sample_tick = one-cycle pulse on the synchronised rising edge.
REQ-017 SHALL implement states IDLE and RUN; IDLE->RUN when run=1; RUN->IDLE in the cycle after run=0.
REQ-018 On entering RUN, SHALL clear step_idx and sample_cnt to 0; step 0 fires on the first sample_tick.
REQ-019 In RUN, at a sample_tick with sample_cnt==0, SHALL fire: trig[v] set for every v with active_pattern[v][step_idx]=1, step_strobe pulsed.
REQ-020 At every sample_tick in RUN, SHALL increment sample_cnt; at eff_len-1 SHALL wrap sample_cnt to 0 and advance step_idx, NUM_STEPS-1 wrapping to 0.
REQ-021 eff_len SHALL be max(samples_per_step, 2*TRIG_HOLD), so every trigger has a low gap of at least TRIG_HOLD samples.
REQ-022 samples_per_step SHALL be sampled only when sample_cnt wraps or on RUN entry; mid-step changes take effect from the next step.
REQ-023 Each fired trig[v] SHALL stay high for exactly TRIG_HOLD sample_ticks and then drop. A re-fire while high reloads the hold count.
REQ-024 pattern_wr SHALL store pattern_data into shadow[pattern_voice] and set pending[pattern_voice]. A repeat write overwrites that shadow entry.
REQ-025 Commit (active<=shadow for pending voices, pending cleared, pattern_ack pulsed) SHALL occur in IDLE in the cycle after a write. In RUN it SHALL occur when step_idx wraps NUM_STEPS-1->0, before step 0 fires.
REQ-026 A write in the same cycle as a commit SHALL be excluded from that commit and stay pending for the next commit.
REQ-027 On RUN->IDLE, SHALL clear trig, step_idx, sample_cnt and hold counters. Pending writes SHALL then commit per REQ-025.
REQ-028 Outputs trig, step_strobe, pattern_ack and step_idx SHALL be registered, with no combinational input-to-output paths.

Reset
REQ-029 rst=0 SHALL asynchronously force IDLE, trig=0, step_idx=0, step_strobe=0 and pattern_ack=0, and clear sample_cnt, hold counters, active, shadow, pending and the sync flops.
REQ-030 Reset asserted mid-step SHALL drop any high trig immediately. Operation SHALL resume only via REQ-018 after release with run=1.

Structure
REQ-031 Package drum_seq_pkg SHALL hold NUM_VOICES, NUM_STEPS, TRIG_HOLD defaults, voice enum (VOICE_KICK=0, VOICE_SNARE, VOICE_HIHAT, VOICE_CLAP), pattern_t (NUM_STEPS bits) and state enum.
REQ-032 The pblrc synchroniser and edge detect SHALL be sub-module pblrc_tick_gen (mclk, rst, pblrc -> sample_tick).

Verification
REQ-033 Write hihat=16'h5555 in IDLE; set samples_per_step=100; run=1. Expect trig[2] high on steps 0,2,4,... every 200 samples, each high for exactly 4 sample_ticks, and step_strobe every 100 samples.
REQ-034 Set samples_per_step=3 with TRIG_HOLD=4. Expect steps every 8 samples; trig low for at least 4 samples between fires.
REQ-035 In RUN at step 5, write kick=16'hFFFF. Expect no kick trig until step 0 after wrap; pattern_ack at the wrap cycle; a write in that same cycle yields a second ack one pattern later.
REQ-036 Drop run while trig high at step 7. Expect trig=0 and step_idx=0 next cycle; run=1 again restarts at step 0.
REQ-037 Assert rst mid-hold. Expect trig=0 asynchronously and patterns cleared (no trig after restart until rewritten).
REQ-038 Change samples_per_step 100->50 mid-step. Expect the current step to last 100 samples and following steps 50.
